// File: rtl/pp_acc_26x34.sv
// pp_acc_26x34: shift-accumulates 26xB partial products into a wide product with valid/ready output
module pp_acc_26x34 #(
    parameter int NLIMB = 4,
    parameter int CW    = 5,
    localparam int RW   = 26*NLIMB+34
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          abort,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [59:0]   in_c,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [RW-1:0] res,
    output logic          busy
);
    typedef enum logic {ACC, DONE} state_t;
    state_t          state_q;
    logic [CW-1:0]   idx_q;
    logic [59:0]     acc_q, sum_d;
    logic [RW-1:0]   res_q, res_d;
    logic            out_valid_q, last_d;
    // carry the previous beat's high part into the new one and place the low 26 bits at the current limb
    always_comb begin
        last_d = idx_q == CW'(NLIMB-1);
        sum_d  = (idx_q == '0 ? 60'd0 : {26'd0, acc_q[59:26]}) + in_c;
        res_d  = res_q;
        for (int k = 0; k < NLIMB; k++)
            if (idx_q == CW'(k)) res_d[26*k +: 26] = sum_d[25:0];
        if (last_d) res_d[RW-1 -: 34] = sum_d[59:26];
    end
    // frame state: abort beats handoff, handoff beats new beats; res survives abort
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ACC;
            idx_q       <= '0;
            acc_q       <= '0;
            res_q       <= '0;
            out_valid_q <= 1'b0;
        end else if (abort) begin
            state_q     <= ACC;
            idx_q       <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
        end else if (state_q == DONE) begin
            if (out_ready) begin
                state_q     <= ACC;
                out_valid_q <= 1'b0;
            end
        end else if (in_valid) begin
            acc_q <= sum_d;
            res_q <= res_d;
            idx_q <= last_d ? '0 : idx_q + 1'b1;
            if (last_d) begin
                state_q     <= DONE;
                out_valid_q <= 1'b1;
            end
        end
    end
    assign in_ready  = state_q == ACC;
    assign out_valid = out_valid_q;
    assign res       = res_q;
    assign busy      = (idx_q != '0) | (state_q == DONE);
endmodule
